// File: rtl/mem_arb_pkg.sv
// Shared widths, grant encoding and SRAM request payload for the memory port arbiter.
package mem_arb_pkg;

  localparam int unsigned MEM_ADDR_W = 9;
  localparam int unsigned MEM_DATA_W = 64;
  localparam int unsigned RSP_DEPTH  = 2;
  localparam int unsigned STARVE_W   = 4;
  localparam int unsigned STARVE_MAX = 15;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_WR   = 2'd1,
    GNT_RD   = 2'd2
  } grant_t;

  typedef struct packed {
    logic                  wen;
    logic                  ren;
    logic [MEM_ADDR_W-1:0] addr;
    logic [MEM_DATA_W-1:0] data;
  } mem_req_t;

endpackage

// File: rtl/mem_rsp_fifo.sv
// Small synchronous response FIFO; head is zero whenever the FIFO is empty.
module mem_rsp_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 64
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         pop,
  output logic [WIDTH-1:0]             head_data,
  output logic                         head_valid,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Next-state for pointers and occupancy; push into a full FIFO only alongside a pop.
  always_comb begin
    do_pop   = pop && (cnt_q != '0);
    do_push  = push && ((cnt_q != CNT_W'(DEPTH)) || do_pop);
    wr_ptr_d = do_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = do_pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    cnt_d    = cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
  end

  // Control state; reset and flush both empty the FIFO.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage needs no reset; contents are masked by the occupancy count.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

  assign head_valid = (cnt_q != '0);
  assign head_data  = head_valid ? mem_q[rd_ptr_q] : '0;
  assign count      = cnt_q;

endmodule

// File: rtl/mem_port_arb.sv
// Arbitrates a write and a read request channel onto one single-port SRAM.
module mem_port_arb
  import mem_arb_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clk_en,
  input  logic                  flush,
  input  logic                  arb_mode,
  input  logic [STARVE_W-1:0]   starve_limit,
  input  logic [MEM_ADDR_W-1:0] wr_addr,
  input  logic [MEM_DATA_W-1:0] wr_data,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [MEM_ADDR_W-1:0] rd_addr,
  input  logic                  rd_addr_valid,
  output logic                  rd_addr_ready,
  output logic [MEM_DATA_W-1:0] rd_data,
  output logic                  rd_data_valid,
  input  logic                  rd_data_ready,
  output logic [MEM_ADDR_W-1:0] addr_to_mem,
  output logic [MEM_DATA_W-1:0] data_to_mem,
  output logic                  wen_to_mem,
  output logic                  ren_to_mem,
  input  logic [MEM_DATA_W-1:0] data_from_mem
);

  localparam int unsigned CNT_W = $clog2(RSP_DEPTH + 1);
  localparam int unsigned OCC_W = CNT_W + 1;

  grant_t              gnt_c;
  grant_t              last_gnt_q, last_gnt_d;
  logic [STARVE_W-1:0] starve_q, starve_d;
  logic                inflight_q, inflight_d;
  logic [CNT_W-1:0]    fifo_cnt;
  logic                fifo_pop;
  logic                advance;
  logic                rd_elig;
  logic                forced_rd;
  mem_req_t            req_c;

  // Grant decision: reads need a free response slot counting the one in flight.
  always_comb begin
    gnt_c     = GNT_NONE;
    advance   = rst_n && clk_en && !flush;
    rd_elig   = rd_addr_valid &&
                ((OCC_W'(fifo_cnt) + OCC_W'(inflight_q)) < OCC_W'(RSP_DEPTH));
    forced_rd = (starve_limit != '0) && (starve_q >= starve_limit);
    if (advance) begin
      if (wr_valid && rd_elig) begin
        if (arb_mode) gnt_c = forced_rd ? GNT_RD : GNT_WR;
        else          gnt_c = (last_gnt_q == GNT_RD) ? GNT_WR : GNT_RD;
      end else if (wr_valid) begin
        gnt_c = GNT_WR;
      end else if (rd_elig) begin
        gnt_c = GNT_RD;
      end
    end
  end

  // Arbitration history and read-starvation bookkeeping.
  always_comb begin
    last_gnt_d = last_gnt_q;
    starve_d   = starve_q;
    inflight_d = (gnt_c == GNT_RD);
    if (gnt_c != GNT_NONE) last_gnt_d = gnt_c;
    if (gnt_c == GNT_RD) begin
      starve_d = '0;
    end else if ((gnt_c == GNT_WR) && rd_elig && (starve_q != STARVE_W'(STARVE_MAX))) begin
      starve_d = starve_q + STARVE_W'(1);
    end
  end

  // State registers; an in-flight capture completes even while clk_en is low.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      last_gnt_q <= GNT_RD;
      starve_q   <= '0;
      inflight_q <= 1'b0;
    end else begin
      inflight_q <= inflight_d;
      if (clk_en) begin
        last_gnt_q <= last_gnt_d;
        starve_q   <= starve_d;
      end
    end
  end

  // SRAM drive for the granted requester; idle drives zeros.
  always_comb begin
    req_c = '0;
    case (gnt_c)
      GNT_WR: begin
        req_c.wen  = 1'b1;
        req_c.addr = wr_addr;
        req_c.data = wr_data;
      end
      GNT_RD: begin
        req_c.ren  = 1'b1;
        req_c.addr = rd_addr;
      end
      default: ;
    endcase
  end

  assign wr_ready      = (gnt_c == GNT_WR);
  assign rd_addr_ready = (gnt_c == GNT_RD);
  assign addr_to_mem   = req_c.addr;
  assign data_to_mem   = req_c.data;
  assign wen_to_mem    = req_c.wen;
  assign ren_to_mem    = req_c.ren;
  assign fifo_pop      = rd_data_valid && rd_data_ready && clk_en;

  mem_rsp_fifo #(
    .DEPTH (RSP_DEPTH),
    .WIDTH (MEM_DATA_W)
  ) u_rsp_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .push       (inflight_q),
    .push_data  (data_from_mem),
    .pop        (fifo_pop),
    .head_data  (rd_data),
    .head_valid (rd_data_valid),
    .count      (fifo_cnt)
  );

endmodule

// File: tb/tb_mem_port_arb.sv
// Bench for mem_port_arb: SRAM stub, outstanding-read model, directed scenarios.
module tb_mem_port_arb;
  import mem_arb_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n, clk_en, flush, arb_mode;
  logic [3:0]  starve_limit;
  logic [8:0]  wr_addr, rd_addr, addr_to_mem;
  logic [63:0] wr_data, rd_data, data_to_mem, data_from_mem;
  logic        wr_valid, wr_ready, rd_addr_valid, rd_addr_ready;
  logic        rd_data_valid, rd_data_ready, wen_to_mem, ren_to_mem;

  always #5 clk = ~clk;

  mem_port_arb dut (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .flush(flush),
    .arb_mode(arb_mode), .starve_limit(starve_limit),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_addr(rd_addr), .rd_addr_valid(rd_addr_valid), .rd_addr_ready(rd_addr_ready),
    .rd_data(rd_data), .rd_data_valid(rd_data_valid), .rd_data_ready(rd_data_ready),
    .addr_to_mem(addr_to_mem), .data_to_mem(data_to_mem),
    .wen_to_mem(wen_to_mem), .ren_to_mem(ren_to_mem), .data_from_mem(data_from_mem)
  );

  int checks = 0;
  int errors = 0;

  task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic check_str(input string name, input string act, input string exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%s expected=%s", name, act, exp);
    end
  endtask

  function automatic logic [63:0] init_val(input logic [8:0] a);
    return 64'hC0DE_0000_0000_0000 | 64'(a);
  endfunction

  // SRAM stub: one-cycle read latency, unwritten words read as init_val.
  logic [63:0]  sram [512];
  logic [511:0] sram_wr;
  always @(posedge clk) begin
    if (!rst_n) sram_wr <= '0;
    else if (wen_to_mem) begin
      sram[addr_to_mem]    <= data_to_mem;
      sram_wr[addr_to_mem] <= 1'b1;
    end
    if (ren_to_mem) data_from_mem <= sram_wr[addr_to_mem] ? sram[addr_to_mem] : init_val(addr_to_mem);
  end

  // Model: list of outstanding reads (granted, not yet consumed), each with its value and ready cycle.
  typedef struct { logic [63:0] data; int avail; } rsp_t;
  rsp_t         mq[$];
  logic [63:0]  shadow [512];
  logic [511:0] shadow_wr = '0;
  int           starve_m  = 0;
  bit           last_rd_m = 1'b1;
  int           cyc       = 0;
  bit           mon_on    = 1'b0;
  string        glog      = "";

  always @(negedge clk) begin : mon_blk
    bit          adv, rd_ok, ew, er, ev;
    logic [63:0] erd, eaddr, edata;
    adv   = rst_n && clk_en && !flush;
    rd_ok = rd_addr_valid && (mq.size() < 2);
    ew = 1'b0;
    er = 1'b0;
    if (adv) begin
      if (wr_valid && rd_ok) begin
        if (arb_mode) begin
          if (starve_limit != 4'd0 && starve_m >= int'(starve_limit)) er = 1'b1;
          else ew = 1'b1;
        end else begin
          if (last_rd_m) ew = 1'b1;
          else er = 1'b1;
        end
      end else begin
        ew = wr_valid;
        er = rd_ok;
      end
    end
    ev    = (mq.size() > 0) && (mq[0].avail <= cyc);
    erd   = ev ? mq[0].data : 64'd0;
    eaddr = ew ? 64'(wr_addr) : (er ? 64'(rd_addr) : 64'd0);
    edata = ew ? wr_data : 64'd0;
    if (mon_on) begin
      check64($sformatf("wr_ready@%0d", cyc), 64'(wr_ready), 64'(ew));
      check64($sformatf("rd_addr_ready@%0d", cyc), 64'(rd_addr_ready), 64'(er));
      check64($sformatf("wen@%0d", cyc), 64'(wen_to_mem), 64'(ew));
      check64($sformatf("ren@%0d", cyc), 64'(ren_to_mem), 64'(er));
      check64($sformatf("addr@%0d", cyc), 64'(addr_to_mem), eaddr);
      check64($sformatf("wdata@%0d", cyc), data_to_mem, edata);
      check64($sformatf("rd_valid@%0d", cyc), 64'(rd_data_valid), 64'(ev));
      check64($sformatf("rd_data@%0d", cyc), rd_data, erd);
    end
    if (wr_ready) glog = {glog, "W"};
    else if (rd_addr_ready) glog = {glog, "R"};
    else glog = {glog, "-"};
    if (!rst_n || flush) begin
      mq.delete();
      starve_m  = 0;
      last_rd_m = 1'b1;
      if (!rst_n) shadow_wr = '0;
    end else if (clk_en) begin
      if (ev && rd_data_ready) void'(mq.pop_front());
      if (ew) begin
        shadow[wr_addr]    = wr_data;
        shadow_wr[wr_addr] = 1'b1;
      end
      if (er) mq.push_back('{data: (shadow_wr[rd_addr] ? shadow[rd_addr] : init_val(rd_addr)),
                             avail: cyc + 2});
      if (er) starve_m = 0;
      else if (ew && rd_ok && starve_m < 15) starve_m++;
      if (ew) last_rd_m = 1'b0;
      else if (er) last_rd_m = 1'b1;
    end
    cyc++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wr_valid = 1'b0; rd_addr_valid = 1'b0;
    wr_addr = '0; wr_data = '0; rd_addr = '0;
  endtask

  task automatic do_flush();
    idle_inputs();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  task automatic read_lit(input logic [8:0] a, input logic [63:0] exp, input string nm);
    idle_inputs();
    rd_addr_valid = 1'b1;
    rd_addr = a;
    @(negedge clk);
    check64({nm, "_grant"}, 64'(rd_addr_ready), 64'd1);
    tick();
    idle_inputs();
    @(negedge clk);
    check64({nm, "_early_valid"}, 64'(rd_data_valid), 64'd0);
    tick();
    @(negedge clk);
    check64({nm, "_valid"}, 64'(rd_data_valid), 64'd1);
    check64({nm, "_data"}, rd_data, exp);
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int    acc;
    bit    last_rdy;
    string exp_s;
    rst_n = 1'b0; clk_en = 1'b1; flush = 1'b0; arb_mode = 1'b0; starve_limit = 4'd4;
    rd_data_ready = 1'b1;
    idle_inputs();
    wr_valid = 1'b1; rd_addr_valid = 1'b1; wr_addr = 9'h3; rd_addr = 9'h4; wr_data = 64'h77;
    repeat (2) tick();
    mon_on = 1'b1;
    tick();
    // Outputs stay quiet under reset even with both requests valid
    @(negedge clk);
    check64("reset_wr_ready", 64'(wr_ready), 64'd0);
    check64("reset_rd_addr_ready", 64'(rd_addr_ready), 64'd0);
    check64("reset_rd_valid", 64'(rd_data_valid), 64'd0);
    check64("reset_wen", 64'(wen_to_mem), 64'd0);
    tick();
    rst_n = 1'b1;
    idle_inputs();
    @(negedge clk);
    check64("idle_rd_data", rd_data, 64'd0);
    check64("idle_ren", 64'(ren_to_mem), 64'd0);
    tick();

    // Four back-to-back writes
    glog = "";
    for (int i = 0; i < 4; i++) begin
      wr_valid = 1'b1; wr_addr = 9'(i); wr_data = 64'hA0 + 64'(i);
      tick();
    end
    idle_inputs();
    tick();
    check_str("wr_burst_log", glog, "WWWW-");
    read_lit(9'h2, 64'hA2, "rd_a2");

    // Write then read, two-cycle latency
    wr_valid = 1'b1; wr_addr = 9'h1F; wr_data = 64'hDEAD;
    tick();
    read_lit(9'h1F, 64'hDEAD, "rd_dead");

    // Read followed by a write to the same address returns the old value
    idle_inputs();
    wr_valid = 1'b1; wr_addr = 9'h20; wr_data = 64'h1111;
    tick();
    idle_inputs();
    rd_addr_valid = 1'b1; rd_addr = 9'h20;
    tick();
    idle_inputs();
    wr_valid = 1'b1; wr_addr = 9'h20; wr_data = 64'h2222;
    @(negedge clk);
    check64("war_wr_grant", 64'(wr_ready), 64'd1);
    tick();
    idle_inputs();
    @(negedge clk);
    check64("war_old_data", rd_data, 64'h1111);
    tick();
    read_lit(9'h20, 64'h2222, "rd_new");

    // Round-robin contention
    do_flush();
    glog = "";
    for (int i = 0; i < 6; i++) begin
      wr_valid = 1'b1; wr_addr = 9'h40 + 9'(i); wr_data = 64'hB0 + 64'(i);
      rd_addr_valid = 1'b1; rd_addr = 9'h1F;
      tick();
    end
    idle_inputs();
    repeat (3) tick();
    check_str("rr_log", glog, "WRWRWR---");

    // Write priority with starvation limit 3
    do_flush();
    arb_mode = 1'b1; starve_limit = 4'd3;
    glog = "";
    for (int i = 0; i < 8; i++) begin
      wr_valid = 1'b1; wr_addr = 9'h50 + 9'(i); wr_data = 64'hC0 + 64'(i);
      rd_addr_valid = 1'b1; rd_addr = 9'h2;
      tick();
    end
    idle_inputs();
    repeat (3) tick();
    check_str("wprio_log", glog, "WWWRWWWR---");

    // Limit 0 never forces; the counter saturates at 15 so limit 15 forces at once
    do_flush();
    starve_limit = 4'd0;
    glog = "";
    exp_s = "";
    for (int i = 0; i < 21; i++) begin
      if (i == 20) starve_limit = 4'd15;
      wr_valid = 1'b1; wr_addr = 9'h90; wr_data = 64'(i);
      rd_addr_valid = 1'b1; rd_addr = 9'h3;
      exp_s = {exp_s, (i == 20) ? "R" : "W"};
      tick();
    end
    idle_inputs();
    repeat (3) tick();
    check_str("starve_sat_log", glog, {exp_s, "---"});
    arb_mode = 1'b0; starve_limit = 4'd4;

    // Back-pressure: only two reads outstanding
    do_flush();
    rd_data_ready = 1'b0;
    acc = 0;
    last_rdy = 1'b0;
    for (int c = 0; c < 6; c++) begin
      rd_addr_valid = 1'b1; rd_addr = 9'h60 + 9'(acc);
      @(negedge clk);
      last_rdy = rd_addr_ready;
      if (rd_addr_ready) acc++;
      tick();
    end
    check64("bp_granted", 64'(acc), 64'd2);
    check64("bp_ready_low", 64'(last_rdy), 64'd0);
    rd_data_ready = 1'b1;
    for (int c = 0; c < 30 && acc < 5; c++) begin
      rd_addr_valid = 1'b1; rd_addr = 9'h60 + 9'(acc);
      @(negedge clk);
      if (c == 0) check64("bp_first_data", rd_data, init_val(9'h60));
      if (rd_addr_ready) acc++;
      tick();
    end
    check64("bp_all_granted", 64'(acc), 64'd5);
    idle_inputs();
    repeat (4) tick();

    // Flush with one queued and one in flight
    rd_data_ready = 1'b0;
    rd_addr_valid = 1'b1; rd_addr = 9'h70;
    tick();
    rd_addr = 9'h71;
    tick();
    idle_inputs();
    flush = 1'b1;
    @(negedge clk);
    check64("flush_pre_valid", 64'(rd_data_valid), 64'd1);
    tick();
    flush = 1'b0;
    rd_data_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check64($sformatf("flush_quiet%0d", i), 64'(rd_data_valid), 64'd0);
      tick();
    end

    // clk_en low: no grants, but the in-flight read still lands
    rd_addr_valid = 1'b1; rd_addr = 9'h1F;
    tick();
    clk_en = 1'b0;
    wr_valid = 1'b1; wr_addr = 9'h5; wr_data = 64'h55; rd_addr = 9'h20;
    repeat (2) tick();
    @(negedge clk);
    check64("cke_hold_valid", 64'(rd_data_valid), 64'd1);
    check64("cke_hold_data", rd_data, 64'hDEAD);
    check64("cke_no_wen", 64'(wen_to_mem), 64'd0);
    tick();
    clk_en = 1'b1;
    idle_inputs();
    repeat (3) tick();

    // Reset mid-operation drops queued responses
    rd_data_ready = 1'b0;
    rd_addr_valid = 1'b1; rd_addr = 9'h80;
    tick();
    rd_addr = 9'h81;
    tick();
    idle_inputs();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    rd_data_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check64($sformatf("rst_quiet%0d", i), 64'(rd_data_valid), 64'd0);
      tick();
    end

    mon_on = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
